// File: rtl/muldiv_seq_pkg.sv
// Shared operation and FSM state encodings for the sequential multiply/divide unit.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DZ,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Start/done handshake and operand/result bundle between the control unit and muldiv_seq.
interface muldiv_seq_if #(parameter int unsigned WIDTH = 32);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_zero
  );

endinterface

// File: rtl/muldiv_abs.sv
// Combinational magnitude extraction: two's-complement absolute value plus sign-out when sgn_en is set.
module muldiv_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             sgn_en,
  output logic [WIDTH-1:0] mag,
  output logic             sgn
);

  always_comb begin
    sgn = sgn_en & val[WIDTH-1];
    mag = sgn ? ('0 - val) : val;
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply (shift-add) / divide (restoring) unit with start/done handshake.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply leaves CALC once remaining multiplier bits are zero).
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt;
  logic             neg_lo;
  logic             neg_hi;
  logic             dz_pend;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;

  logic             is_mult;
  logic             signed_op;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_sgn;
  logic             b_sgn;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod_al;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             mul_rest_zero;
  logic             calc_last;

  assign is_mult   = ~op_is_div(op_q);
  assign signed_op = op_is_signed(op_q);

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
    .val    (a_q),
    .sgn_en (signed_op),
    .mag    (a_mag),
    .sgn    (a_sgn)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
    .val    (b_q),
    .sgn_en (signed_op),
    .mag    (b_mag),
    .sgn    (b_sgn)
  );

  // a_q holds the multiplicand magnitude, b_q the multiplier/divisor magnitude after PREP.
  always_comb begin
    mul_sum   = {1'b0, acc} + {1'b0, (sr[0] ? a_q : '0)};
    div_shift = {acc, sr[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [31:0] next_pos;
  logic [31:0] align_sh;

  // After cnt+1 steps with zero leftover multiplier bits, the product sits
  // (WIDTH-1-cnt) places too high in {acc,sr}; the FIX shift realigns it.
  always_comb begin
    next_pos      = 32'(cnt) + 32'd1;
    align_sh      = 32'(WIDTH - 1) - 32'(cnt);
    mul_rest_zero = ((b_q >> next_pos) == '0);
    prod_al       = {acc, sr} >> align_sh;
  end
`else
  always_comb begin
    mul_rest_zero = 1'b0;
    prod_al       = {acc, sr};
  end
`endif

  always_comb begin
    prod_fix  = neg_lo ? ('0 - prod_al) : prod_al;
    quot_fix  = neg_lo ? ('0 - sr)  : sr;
    rem_fix   = neg_hi ? ('0 - acc) : acc;
    calc_last = (cnt == CW'(WIDTH - 1)) || (is_mult && mul_rest_zero);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      sr      <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt     <= '0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      dz_pend <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= op_e'(bus.op);
            busy_q  <= 1'b1;
            dz_q    <= 1'b0;
            dz_pend <= 1'b0;
            state   <= (bus.op[1] && (bus.b == '0)) ? S_DZ : S_PREP;
          end
        end
        S_DZ: begin
          dz_pend <= 1'b1;
          state   <= S_DONE;
        end
        S_PREP: begin
          a_q    <= a_mag;
          b_q    <= b_mag;
          sr     <= is_mult ? b_mag : a_mag;
          acc    <= '0;
          cnt    <= '0;
          neg_lo <= a_sgn ^ b_sgn;
          neg_hi <= a_sgn;
          state  <= S_CALC;
        end
        S_CALC: begin
          if (is_mult) begin
            acc <= mul_sum[WIDTH:1];
            sr  <= {mul_sum[0], sr[WIDTH-1:1]};
          end else begin
            acc <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            sr  <= {sr[WIDTH-2:0], ~div_diff[WIDTH]};
          end
          if (calc_last) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FIX: begin
          if (is_mult) begin
            {hi_q, lo_q} <= prod_fix;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          dz_q   <= dz_pend;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq at WIDTH=32.
module tb_muldiv_seq;

  localparam int unsigned W = 32;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   edges;
  int   ndone;
  int   first_done;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one start pulse and waits (bounded) for done; edges = clock edges after the sampling edge.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h1234_5678;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_seen", 64'(bus.done), 64'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi",   64'(bus.hi),   64'd0);
    check("rst_lo",   64'(bus.lo),   64'd0);
    check("rst_dz",   64'(bus.div_zero), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges);
    check("multu_max_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(bus.lo), 64'h0000_0001);
    check("multu_max_lat", 64'(edges), 64'd35);
    check("multu_busy_low", 64'(bus.busy), 64'd0);

    run_op(2'b00, 32'hFFFF_FFF9, 32'd6, edges);
    check("mult_m7x6_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_m7x6_lo", 64'(bus.lo), 64'hFFFF_FFD6);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges);
    check("mult_m1xm1_hi", 64'(bus.hi), 64'h0);
    check("mult_m1xm1_lo", 64'(bus.lo), 64'h1);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, edges);
    check("div_m7d2_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    check("div_m7d2_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("div_lat", 64'(edges), 64'd35);

    run_op(2'b11, 32'd100, 32'd0, edges);
    check("dz_flag", 64'(bus.div_zero), 64'd1);
    check("dz_lat",  64'(edges), 64'd2);
    check("dz_hi_keep", 64'(bus.hi), 64'hFFFF_FFFF);
    check("dz_lo_keep", 64'(bus.lo), 64'hFFFF_FFFD);

    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, edges);
    check("dz_cleared", 64'(bus.div_zero), 64'd0);
    check("div_7dm2_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    check("div_7dm2_hi", 64'(bus.hi), 64'h1);

    // MIN_INT / -1 with a second start pulsed while busy.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'h8000_0000;
    bus.b     = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    edges      = 0;
    ndone      = 0;
    first_done = 0;
    while (edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 5) begin
        check("busy_mid", 64'(bus.busy), 64'd1);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
      end
      if (edges == 6) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        if (first_done == 0) begin
          first_done = edges;
          check("minint_lo", 64'(bus.lo), 64'h8000_0000);
          check("minint_hi", 64'(bus.hi), 64'h0);
          check("minint_dz", 64'(bus.div_zero), 64'd0);
        end
      end
    end
    check("ignore_ndone", 64'(ndone), 64'd1);
    check("ignore_lat",   64'(first_done), 64'd35);

    // Abort in CALC at count 10 (CALC entered at edge E+1).
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'd1000;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hi",   64'(bus.hi),   64'd0);
    check("abort_lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(2'b11, 32'd17, 32'd5, edges);
    check("divu_17d5_lo", 64'(bus.lo), 64'd3);
    check("divu_17d5_hi", 64'(bus.hi), 64'd2);

    run_op(2'b01, 32'd9, 32'd3, edges);
    check("multu_9x3_hi", 64'(bus.hi), 64'd0);
    check("multu_9x3_lo", 64'(bus.lo), 64'd27);
`ifdef MULDIV_EARLY_OUT_EN
    check("multu_9x3_lat", 64'(edges), 64'd5);
`else
    check("multu_9x3_lat", 64'(edges), 64'd35);
`endif

    run_op(2'b00, 32'h1234_5678, 32'd0, edges);
    check("mult_x0_hi", 64'(bus.hi), 64'd0);
    check("mult_x0_lo", 64'(bus.lo), 64'd0);
`ifdef MULDIV_EARLY_OUT_EN
    check("mult_x0_lat", 64'(edges), 64'd4);
`else
    check("mult_x0_lat", 64'(edges), 64'd35);
`endif

    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, edges);
    check("mult_min2_hi", 64'(bus.hi), 64'h4000_0000);
    check("mult_min2_lo", 64'(bus.lo), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
